// File: rtl/pipelined_sum_unit.sv
// rtl/pipelined_sum_unit.sv - pipelined add/saturate/subtract/accumulate unit with valid/ready handshake
`timescale 1ns/1ps
module pipelined_sum_unit #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_sat,
  output logic [WIDTH-1:0] acc_value
);

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SAT = 2'b01;
  localparam logic [1:0] MODE_SUB = 2'b10;
  localparam logic [1:0] MODE_ACC = 2'b11;
  localparam int         DW       = WIDTH + 2;

  logic             en;
  logic             accept;
  logic             acc_beat;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH+1:0] acc_full;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] calc_sum;
  logic             calc_carry;
  logic             calc_sat;

  // Each stage carries {sat, carry, sum}; only stage 0 does arithmetic.
  logic [LATENCY-1:0] vld_q;
  logic [DW-1:0]      stage_q [LATENCY];

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign acc_beat = accept && (in_mode == MODE_ACC);

  assign add_full = {1'b0, in_a} + {1'b0, in_b};
  assign sub_full = {1'b0, in_a} - {1'b0, in_b};
  // Clear-then-add when acc_clr coincides with an accumulate beat.
  assign acc_base = acc_clr ? '0 : acc_q;
  assign acc_full = {2'b00, acc_base} + {2'b00, in_a} + {2'b00, in_b};

  always_comb begin
    calc_sum   = add_full[WIDTH-1:0];
    calc_carry = add_full[WIDTH];
    calc_sat   = 1'b0;
    case (in_mode)
      MODE_ADD: ;
      MODE_SAT: begin
        if (add_full[WIDTH]) begin
          calc_sum = '1;
          calc_sat = 1'b1;
        end
      end
      MODE_SUB: begin
        calc_sum   = sub_full[WIDTH-1:0];
        calc_carry = sub_full[WIDTH];
      end
      MODE_ACC: begin
        calc_sum   = acc_full[WIDTH-1:0];
        calc_carry = |acc_full[WIDTH+1:WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else if (en) begin
      vld_q[0] <= accept;
      if (accept) begin
        stage_q[0] <= {calc_sat, calc_carry, calc_sum};
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i]   <= vld_q[i-1];
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Accumulator clears on acc_clr even while the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (acc_beat) begin
      acc_q <= acc_full[WIDTH-1:0];
    end else if (acc_clr) begin
      acc_q <= '0;
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_sum   = stage_q[LATENCY-1][WIDTH-1:0];
  assign out_carry = stage_q[LATENCY-1][WIDTH];
  assign out_sat   = stage_q[LATENCY-1][WIDTH+1];
  assign acc_value = acc_q;

endmodule

// File: tb/tb_pipelined_sum_unit.sv
// tb/tb_pipelined_sum_unit.sv - directed and randomized scoreboard bench for pipelined_sum_unit
`timescale 1ns/1ps
module tb_pipelined_sum_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Directed instance, WIDTH=8 LATENCY=2
  logic       d_rst, d_in_valid, d_in_ready, d_clr, d_out_valid, d_out_ready, d_carry, d_sat;
  logic [7:0] d_a, d_b, d_sum, d_acc;
  logic [1:0] d_mode;

  pipelined_sum_unit #(.WIDTH(8), .LATENCY(2)) u_dut_d (
    .clk       (clk),
    .rst       (d_rst),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .in_a      (d_a),
    .in_b      (d_b),
    .in_mode   (d_mode),
    .acc_clr   (d_clr),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .out_sum   (d_sum),
    .out_carry (d_carry),
    .out_sat   (d_sat),
    .acc_value (d_acc)
  );

  task automatic d_send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] mode,
                        input logic clr, input logic [7:0] esum, input logic ecarry,
                        input logic esat, input string tag);
    @(negedge clk);
    d_in_valid = 1'b1; d_a = a; d_b = b; d_mode = mode; d_clr = clr;
    #1 check_eq({tag, "_in_ready"}, d_in_ready, 1);
    @(negedge clk);
    d_in_valid = 1'b0; d_clr = 1'b0;
    check_eq({tag, "_early"}, d_out_valid, 0);
    @(negedge clk);
    check_eq({tag, "_valid"}, d_out_valid, 1);
    check_eq({tag, "_sum"}, d_sum, esum);
    check_eq({tag, "_carry"}, d_carry, ecarry);
    check_eq({tag, "_sat"}, d_sat, esat);
  endtask

  // Randomized scoreboard instances at three configurations
  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int W = (g == 1) ? 4 : (g == 2) ? 16 : 8;
    localparam int L = (g == 1) ? 1 : (g == 2) ? 4 : 2;
    localparam int M = 1 << W;

    logic         rst, in_valid, in_ready, acc_clr, out_valid, out_ready, out_carry, out_sat;
    logic [W-1:0] in_a, in_b, out_sum, acc_value;
    logic [1:0]   in_mode;
    bit           done = 1'b0;
    int           exp_q[$];

    pipelined_sum_unit #(.WIDTH(W), .LATENCY(L)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_mode   (in_mode),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .out_sat   (out_sat),
      .acc_value (acc_value)
    );

    function automatic int pick_operand();
      case ($urandom_range(3))
        0:       return 0;
        1:       return M - 1;
        default: return int'($urandom_range(M - 1));
      endcase
    endfunction

    function automatic int pack(input int s, input int c, input int sat);
      return (sat << (W + 1)) | (c << W) | s;
    endfunction

    initial begin
      int  acc_m = 0;
      int  held  = 0;
      bit  holding = 1'b0;
      int  a, b, t, got;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0;
      acc_clr = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int cyc = 0; cyc < 400 + L + 8; cyc++) begin
        @(negedge clk);
        check_eq($sformatf("w%0d_acc_value", W), 32'(acc_value), acc_m);
        got = int'({out_sat, out_carry, out_sum});
        if (holding) begin
          check_eq($sformatf("w%0d_hold_valid", W), out_valid, 1);
          check_eq($sformatf("w%0d_hold_data", W), got, held);
        end
        a = pick_operand();
        b = pick_operand();
        in_valid  = (cyc < 400) && ($urandom_range(3) != 0);
        out_ready = (cyc >= 400) || ($urandom_range(9) < 7);
        in_a      = W'(a);
        in_b      = W'(b);
        in_mode   = 2'($urandom_range(3));
        acc_clr   = ($urandom_range(9) == 0);
        #1;
        check_eq($sformatf("w%0d_in_ready", W), in_ready, !out_valid || out_ready);
        holding = out_valid && !out_ready;
        held    = got;
        if (out_valid && out_ready) begin
          check_eq($sformatf("w%0d_q_nonempty", W), exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check_eq($sformatf("w%0d_result", W), got, exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
          case (in_mode)
            2'b00: exp_q.push_back(pack((a + b) % M, (a + b >= M) ? 1 : 0, 0));
            2'b01: exp_q.push_back((a + b >= M) ? pack(M - 1, 1, 1) : pack(a + b, 0, 0));
            2'b10: exp_q.push_back(pack((a - b + M) % M, (a < b) ? 1 : 0, 0));
            default: begin
              t = (acc_clr ? 0 : acc_m) + a + b;
              exp_q.push_back(pack(t % M, (t >= M) ? 1 : 0, 0));
            end
          endcase
        end
        if (in_valid && in_ready && in_mode == 2'b11) acc_m = t % M;
        else if (acc_clr) acc_m = 0;
      end
      check_eq($sformatf("w%0d_drain", W), exp_q.size(), 0);
      done = 1'b1;
    end
  end

  initial begin
    bit ghost = 1'b0;
    d_rst = 1'b1; d_in_valid = 1'b0; d_a = '0; d_b = '0; d_mode = '0; d_clr = 1'b0;
    d_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", d_out_valid, 0);
    check_eq("rst_out_sum", d_sum, 0);
    check_eq("rst_out_carry", d_carry, 0);
    check_eq("rst_out_sat", d_sat, 0);
    check_eq("rst_acc", d_acc, 0);
    check_eq("rst_in_ready", d_in_ready, 1);
    d_rst = 1'b0;

    d_send(8'h30, 8'h45, 2'b00, 1'b0, 8'h75, 1'b0, 1'b0, "add0");
    d_send(8'hF0, 8'h20, 2'b00, 1'b0, 8'h10, 1'b1, 1'b0, "add1");
    d_send(8'hC8, 8'h64, 2'b01, 1'b0, 8'hFF, 1'b1, 1'b1, "sat0");
    d_send(8'h10, 8'h10, 2'b01, 1'b0, 8'h20, 1'b0, 1'b0, "sat1");
    d_send(8'h05, 8'h07, 2'b10, 1'b0, 8'hFE, 1'b1, 1'b0, "sub0");
    check_eq("acc_untouched", d_acc, 8'h00);
    d_send(8'h01, 8'h02, 2'b11, 1'b0, 8'h03, 1'b0, 1'b0, "acc0");
    d_send(8'h03, 8'h04, 2'b11, 1'b0, 8'h0A, 1'b0, 1'b0, "acc1");
    d_send(8'h80, 8'h80, 2'b11, 1'b0, 8'h0A, 1'b1, 1'b0, "acc2");
    check_eq("acc_after_wrap", d_acc, 8'h0A);
    d_send(8'h05, 8'h05, 2'b11, 1'b1, 8'h0A, 1'b0, 1'b0, "acc_clr_beat");
    check_eq("acc_after_clr_beat", d_acc, 8'h0A);
    @(negedge clk); d_clr = 1'b1;
    @(negedge clk); d_clr = 1'b0;
    check_eq("acc_clr_alone", d_acc, 8'h00);

    d_send(8'h40, 8'h00, 2'b11, 1'b0, 8'h40, 1'b0, 1'b0, "acc40");
    check_eq("acc_pre_rst", d_acc, 8'h40);
    @(negedge clk); d_in_valid = 1'b1; d_a = 8'h01; d_b = 8'h01; d_mode = 2'b00;
    @(negedge clk); d_a = 8'h02; d_b = 8'h02;
    @(negedge clk); d_in_valid = 1'b0;
    check_eq("inflight_visible", d_out_valid, 1);
    d_rst = 1'b1;
    #1;
    check_eq("async_rst_valid", d_out_valid, 0);
    check_eq("async_rst_acc", d_acc, 0);
    check_eq("async_rst_in_ready", d_in_ready, 1);
    @(negedge clk); d_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ghost |= d_out_valid;
    end
    check_eq("no_ghost_beats", ghost, 0);
    d_send(8'h11, 8'h22, 2'b00, 1'b0, 8'h33, 1'b0, 1'b0, "post_rst");

    for (int i = 0; i < 20000 && !(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done); i++)
      @(negedge clk);
    check_eq("random_done", {g_rnd[2].done, g_rnd[1].done, g_rnd[0].done}, 3'b111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
